muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle for
// 32 cycles. Signed codes iterate on magnitudes; the sign is applied on the
// way into DONE. Divide-by-zero and the signed-overflow divide short-circuit
// straight to DONE.
//
// Optional build macro: MULDIV_FAST_MUL_EN -- all multiply codes finish in one
// cycle through a 64-bit multiplier (IDLE -> DONE); division is unchanged.
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   start_i             begin an operation (looked at only in IDLE)
//   alu_ctrl_i[4:0]     ALU code; only the eight M-extension codes are accepted
//   op_a_i, op_b_i      rs1 / rs2 operands
//   flush_i             abort whatever is in flight, back to IDLE
//   busy_o              high in MUL / DIV states (hazard stall)
//   done_o              one-cycle pulse, result_o valid
//   result_o            result, held until the next accepted operation completes
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [4:0]  alu_ctrl_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  // M-extension codes (mirrors defines.v)
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // product accumulator; low half starts as |b|
  logic [31:0] mag_q, mag_d;     // |multiplicand| or |divisor|
  logic [32:0] rem_q, rem_d;     // partial remainder
  logic [31:0] quo_q, quo_d;     // dividend shifts out the top, quotient in the bottom
  logic        neg_q, neg_d;     // negate the final result
  logic        hi_q, hi_d;       // multiply returns product[63:32]
  logic        rsel_q, rsel_d;   // divide returns remainder
  logic [31:0] result_q, result_d;

  // ---- input decode (used only in IDLE) ----
  logic is_mul, is_div, is_sdiv, is_rem, is_hi, a_sgn, b_sgn, neg_in;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    is_mul  = (alu_ctrl_i == ALU_MUL)  || (alu_ctrl_i == ALU_MULH) ||
              (alu_ctrl_i == ALU_MULHSU) || (alu_ctrl_i == ALU_MULHU);
    is_div  = (alu_ctrl_i == ALU_DIV)  || (alu_ctrl_i == ALU_DIVU) ||
              (alu_ctrl_i == ALU_REM)  || (alu_ctrl_i == ALU_REMU);
    is_sdiv = (alu_ctrl_i == ALU_DIV)  || (alu_ctrl_i == ALU_REM);
    is_rem  = (alu_ctrl_i == ALU_REM)  || (alu_ctrl_i == ALU_REMU);
    is_hi   = (alu_ctrl_i == ALU_MULH) || (alu_ctrl_i == ALU_MULHSU) ||
              (alu_ctrl_i == ALU_MULHU);
    a_sgn   = ((alu_ctrl_i == ALU_MULH) || (alu_ctrl_i == ALU_MULHSU) || is_sdiv) && op_a_i[31];
    b_sgn   = ((alu_ctrl_i == ALU_MULH) || is_sdiv) && op_b_i[31];
    a_mag   = a_sgn ? -op_a_i : op_a_i;
    b_mag   = b_sgn ? -op_b_i : op_b_i;
    // remainder follows the dividend; quotient/product follow the sign xor
    neg_in  = is_rem ? a_sgn : (a_sgn ^ b_sgn);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fa, fb, fprod;
  logic [31:0] fast_res;
  always_comb begin
    fa       = {{32{a_sgn}}, op_a_i};
    fb       = {{32{b_sgn}}, op_b_i};
    fprod    = fa * fb;  // low 64 bits of the sign-extended product are exact
    fast_res = is_hi ? fprod[63:32] : fprod[31:0];
  end
`endif

  // ---- one iteration step ----
  logic [32:0] msum;
  logic [63:0] mul_nxt, prod_fix;
  logic [33:0] dshift, ddiff;
  logic        fits;
  logic [32:0] rem_nxt;
  logic [31:0] quo_nxt, mul_res, div_res, quo_fix, rem_fix;

  always_comb begin
    msum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    mul_nxt  = {msum, acc_q[31:1]};
    prod_fix = neg_q ? -mul_nxt : mul_nxt;
    mul_res  = hi_q ? prod_fix[63:32] : prod_fix[31:0];

    dshift   = {rem_q, quo_q[31]};
    ddiff    = dshift - {2'b00, mag_q};
    fits     = ~ddiff[33];
    rem_nxt  = fits ? ddiff[32:0] : dshift[32:0];
    quo_nxt  = {quo_q[30:0], fits};
    quo_fix  = neg_q ? -quo_nxt : quo_nxt;
    rem_fix  = neg_q ? -rem_nxt[31:0] : rem_nxt[31:0];
    div_res  = rsel_q ? rem_fix : quo_fix;
  end

  // ---- next state ----
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    rsel_d   = rsel_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && (is_mul || is_div)) begin
          neg_d  = neg_in;
          hi_d   = is_hi;
          rsel_d = is_rem;
          cnt_d  = 5'd0;
          if (is_div) begin
            if (op_b_i == 32'd0) begin
              result_d = is_rem ? op_a_i : 32'hFFFF_FFFF;
              state_d  = S_DONE;
            end else if (is_sdiv && op_a_i == 32'h8000_0000 && op_b_i == 32'hFFFF_FFFF) begin
              result_d = is_rem ? 32'd0 : 32'h8000_0000;
              state_d  = S_DONE;
            end else begin
              rem_d   = 33'd0;
              quo_d   = a_mag;
              mag_d   = b_mag;
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = fast_res;
            state_d  = S_DONE;
`else
            acc_d   = {32'd0, b_mag};
            mag_d   = a_mag;
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = mul_res;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;  // S_DONE
    endcase

    // flush drops any start and any result about to land
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      rsel_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      rsel_q   <= rsel_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and latency, plus
// hand-written sequences for ignored starts, flush, and reset mid-operation.
module tb_muldiv_unit;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ctrl = '0;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .alu_ctrl_i(ctrl),
    .op_a_i(a), .op_b_i(b), .flush_i(flush),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // cycles from start edge to done
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // iterative ops take 33 cycles to done; fast build multiplies take 1
  function automatic int mul_lat();
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation in the current cycle (T), watches busy each cycle,
  // and checks latency, result and the return to IDLE.
  task automatic run_op(input string name, input vec_t v);
    int k;
    int got_lat;
    logic busy_bad;
    start = 1'b1; ctrl = v.code; a = v.a; b = v.b;
    step();
    start = 1'b0;
    got_lat  = 0;
    busy_bad = 1'b0;
    for (k = 1; k <= 40; k++) begin
      if (busy !== (k < v.lat)) busy_bad = 1'b1;
      if (done === 1'b1) begin
        got_lat = k;
        break;
      end
      step();
    end
    chk({name, " busy"}, {31'd0, busy_bad}, 32'd0);
    chk({name, " latency"}, got_lat, v.lat);
    chk({name, " result"}, result, v.exp);
    step();
    chk({name, " idle"}, {30'd0, busy, done}, 32'd0);
    chk({name, " hold"}, result, v.exp);
  endtask

  vec_t vecs[18];

  initial begin
    int ml;
    int k;
    logic seen;
    logic [31:0] held;
    ml = mul_lat();
    vecs[0]  = '{ALU_MUL,    32'd7,          32'd6,          32'd42,         ml};
    vecs[1]  = '{ALU_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   ml};
    vecs[2]  = '{ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   ml};
    vecs[3]  = '{ALU_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   ml};
    vecs[4]  = '{ALU_MUL,    32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   ml};
    vecs[5]  = '{ALU_MULH,   32'h80000000,   32'h80000000,   32'h40000000,   ml};
    vecs[6]  = '{ALU_MULHSU, 32'd3,          32'hFFFFFFFF,   32'd2,          ml};
    vecs[7]  = '{ALU_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
    vecs[8]  = '{ALU_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
    vecs[9]  = '{ALU_DIVU,   32'd100,        32'd3,          32'd33,         33};
    vecs[10] = '{ALU_REMU,   32'd100,        32'd3,          32'd1,          33};
    vecs[11] = '{ALU_DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33};
    vecs[12] = '{ALU_REM,    32'd7,          32'hFFFFFFFE,   32'd1,          33};
    vecs[13] = '{ALU_DIVU,   32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[14] = '{ALU_REMU,   32'd5,          32'd0,          32'd5,          1};
    vecs[15] = '{ALU_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    vecs[16] = '{ALU_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    vecs[17] = '{ALU_REMU,   32'hFFFFFFFF,   32'h10,         32'hF,          33};

    // reset state
    step(); step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 18; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // non-M code start in IDLE is ignored
    held = result;
    start = 1'b1; ctrl = ALU_ADD; a = 32'd1; b = 32'd0;
    step();
    start = 1'b0;
    chk("nonM busy", {31'd0, busy}, 32'd0);
    chk("nonM done", {31'd0, done}, 32'd0);
    chk("nonM result", result, held);

    // flush and start together in IDLE: start dropped (div-by-0 would finish at T+1)
    start = 1'b1; flush = 1'b1; ctrl = ALU_DIVU; a = 32'd5; b = 32'd0;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush+start done", {31'd0, done}, 32'd0);
    chk("flush+start busy", {31'd0, busy}, 32'd0);
    chk("flush+start result", result, held);

    // start during an iterative op is ignored
    start = 1'b1; ctrl = ALU_DIVU; a = 32'd1000; b = 32'd10;
    step();                                 // now T+1
    start = 1'b1; ctrl = ALU_REMU; a = 32'd9; b = 32'd0;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (k = 2; k <= 40 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else step();
    end
    chk("busy-start latency", k - 1, 33);
    chk("busy-start result", result, 32'd100);
    step();

    // flush mid-divide: DIV 100/3 at T, flush at T+10
    held = result;
    start = 1'b1; ctrl = ALU_DIV; a = 32'd100; b = 32'd3;
    step();                                 // T+1
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();     // T+10
    flush = 1'b1;
    step();                                 // T+11
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush result", result, held);
    step();                                 // T+12: new start accepted
    run_op("post-flush", '{ALU_DIV, 32'd100, 32'd3, 32'd33, 33});

    // reset mid-multiply: no done, result cleared
    start = 1'b1; ctrl = ALU_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst-mid busy", {31'd0, busy}, 32'd0);
    chk("rst-mid result", result, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      step();
    end
    chk("rst-mid no done", {31'd0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
